// File: rtl/dp_pkg.sv
// dp_pkg: opcodes, ext codes, condition codes, FSM states and flag indices.
// DP_ARITH_SHIFT_EN makes LSH ext 0001 decode as an arithmetic shift.
package dp_pkg;

    localparam logic [3:0] OP_ALU  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_MOVI = 4'b1101;
    localparam logic [3:0] OP_MEM  = 4'b0100;
    localparam logic [3:0] OP_SHF  = 4'b1000;
    localparam logic [3:0] OP_BCC  = 4'b1100;

    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;
    localparam logic [3:0] EXT_LSH  = 4'b0000;
    localparam logic [3:0] EXT_ASH  = 4'b0001;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_AL = 4'b1110;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_DEC  = 3'd1;
    localparam state_t S_EXE  = 3'd2;
    localparam state_t S_MEM  = 3'd3;
    localparam state_t S_WB   = 3'd4;

    localparam int FC = 4;
    localparam int FL = 3;
    localparam int FF = 2;
    localparam int FZ = 1;
    localparam int FN = 0;

    typedef enum logic [3:0] {
        K_ILL, K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_CMP, K_MOV,
        K_ADDI, K_MOVI, K_LOAD, K_STOR, K_LSH, K_ASH, K_BCC
    } kind_t;

    function automatic kind_t decode(input logic [15:0] ins);
        logic [3:0] op, sel, ext;
        kind_t      k;
        op  = ins[15:12];
        sel = ins[11:8];
        ext = ins[7:4];
        k   = K_ILL;
        unique case (1'b1)
            op == OP_ALU && ext == EXT_ADD:  k = K_ADD;
            op == OP_ALU && ext == EXT_SUB:  k = K_SUB;
            op == OP_ALU && ext == EXT_AND:  k = K_AND;
            op == OP_ALU && ext == EXT_OR:   k = K_OR;
            op == OP_ALU && ext == EXT_XOR:  k = K_XOR;
            op == OP_ALU && ext == EXT_CMP:  k = K_CMP;
            op == OP_ALU && ext == EXT_MOV:  k = K_MOV;
            op == OP_ADDI:                   k = K_ADDI;
            op == OP_MOVI:                   k = K_MOVI;
            op == OP_MEM && ext == EXT_LOAD: k = K_LOAD;
            op == OP_MEM && ext == EXT_STOR: k = K_STOR;
            op == OP_SHF && ext == EXT_LSH:  k = K_LSH;
`ifdef DP_ARITH_SHIFT_EN
            op == OP_SHF && ext == EXT_ASH:  k = K_ASH;
`endif
            op == OP_BCC && (sel == CC_EQ || sel == CC_NE || sel == CC_AL):
                k = K_BCC;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// mc_datapath_if: instruction handshake and memory req/ack bus.
// master = environment side, slave = datapath side.
interface mc_datapath_if #(
    parameter int DW = 16
);
    logic [15:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        output instr, instr_valid, mem_ack, mem_rdata,
        input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  instr, instr_valid, mem_ack, mem_rdata,
        output instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dp_regfile.sv
// dp_regfile: NREGS x DW register file, two async reads, one sync write,
// cleared by the asynchronous reset.
module dp_regfile #(
    parameter int DW    = 16,
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    output logic [DW-1:0] rda,
    output logic [DW-1:0] rdb,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);
    logic [DW-1:0] r [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r[i] <= '0;
        end else if (we) begin
            r[wa] <= wd;
        end
    end

    assign rda = r[ra];
    assign rdb = r[rb];
endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle datapath with inline ALU, shifter and sequencer.
// Optional feature macro: DP_ARITH_SHIFT_EN (arithmetic LSH, ext 0001).
module mc_datapath
    import dp_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NREGS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_datapath_if.slave  bus,
    output logic [DW-1:0] pc,
    output logic [4:0]    flags,
    output logic          illegal
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t        state;
    logic [15:0]   ir;
    logic [DW-1:0] a, b, imm, res;
    logic [DW-1:0] rda, rdb, bop, alu;
    logic [DW-1:0] shl, shr, sra, shres;
    logic [DW:0]   sum, dif;
    logic [4:0]    mag, flags_nx;
    logic          taken, wb_en, is_mem;
    kind_t         k;

    assign k = decode(ir);

    dp_regfile #(
        .DW(DW), .NREGS(NREGS), .AW(AW)
    ) u_rf (
        .clk  (clk),
        .rst_n(rst_n),
        .ra   (ir[8 +: AW]),
        .rb   (ir[0 +: AW]),
        .rda  (rda),
        .rdb  (rdb),
        .we   (wb_en),
        .wa   (ir[8 +: AW]),
        .wd   (res)
    );

    assign bop = (k == K_ADDI) ? imm : b;
    assign sum = {1'b0, a} + {1'b0, bop};
    assign dif = {1'b0, a} - {1'b0, b};

    // imm holds the sign-extended shift count; negative means right
    assign mag   = imm[DW-1] ? 5'(-imm) : 5'(imm);
    assign shl   = a << mag;
    assign sra   = $signed(a) >>> mag;
    assign shr   = (k == K_ASH) ? sra : (a >> mag);
    assign shres = (32'(mag) >= DW) ? '0 : (imm[DW-1] ? shr : shl);

    always_comb begin
        alu = a;
        unique case (k)
            K_ADD, K_ADDI: alu = sum[DW-1:0];
            K_SUB:         alu = dif[DW-1:0];
            K_AND:         alu = a & b;
            K_OR:          alu = a | b;
            K_XOR:         alu = a ^ b;
            K_MOV:         alu = b;
            K_MOVI:        alu = imm;
            K_LSH, K_ASH:  alu = shres;
            default:       alu = a;
        endcase
    end

    always_comb begin
        flags_nx = flags;
        unique case (k)
            K_ADD, K_ADDI: begin
                flags_nx[FC] = sum[DW];
                flags_nx[FF] = (a[DW-1] == bop[DW-1]) &&
                               (sum[DW-1] != a[DW-1]);
            end
            K_SUB: begin
                flags_nx[FC] = dif[DW];
                flags_nx[FF] = (a[DW-1] != b[DW-1]) &&
                               (dif[DW-1] != a[DW-1]);
            end
            K_CMP: begin
                flags_nx[FZ] = (a == b);
                flags_nx[FL] = (a < b);
                flags_nx[FN] = ($signed(a) < $signed(b));
            end
            default: ;
        endcase
    end

    assign taken = (k == K_BCC) &&
                   ((ir[11:8] == CC_AL) ||
                    (ir[11:8] == CC_EQ && flags[FZ]) ||
                    (ir[11:8] == CC_NE && !flags[FZ]));

    assign is_mem = (k == K_LOAD) || (k == K_STOR);
    assign wb_en  = (state == S_WB) &&
                    !(k inside {K_CMP, K_STOR, K_BCC, K_ILL});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ir    <= '0;
            a     <= '0;
            b     <= '0;
            imm   <= '0;
            res   <= '0;
            flags <= '0;
            pc    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        ir    <= bus.instr;
                        state <= S_DEC;
                    end
                end
                S_DEC: begin
                    a     <= rda;
                    b     <= rdb;
                    imm   <= (k == K_LSH || k == K_ASH) ?
                             DW'(signed'(ir[3:0])) :
                             DW'(signed'(ir[7:0]));
                    state <= S_EXE;
                end
                S_EXE: begin
                    res   <= alu;
                    flags <= flags_nx;
                    state <= is_mem ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (bus.mem_ack) begin
                        if (k == K_LOAD) res <= bus.mem_rdata;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    pc    <= taken ? (pc + imm) : (pc + DW'(1));
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // outputs decode straight from state so reset drops them asynchronously
    assign bus.instr_ready = (state == S_IDLE);
    assign bus.mem_req     = (state == S_MEM);
    assign bus.mem_we      = (state == S_MEM) && (k == K_STOR);
    assign bus.mem_addr    = b;
    assign bus.mem_wdata   = a;
    assign illegal         = (state == S_WB) && (k == K_ILL);
endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed and random instruction stream checked against
// an integer-arithmetic model of the instruction set.
module tb_mc_datapath;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pc;
    logic [4:0]    flags;
    logic          illegal;

    mc_datapath_if #(.DW(DW)) bus ();

    mc_datapath #(.DW(DW), .NREGS(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .pc     (pc),
        .flags  (flags),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ill;
        logic        mem;
        logic        st;
        logic [15:0] addr;
        logic [15:0] wdata;
    } exp_t;

    int         n_assert = 0;
    int         n_fail = 0;
    int         mr [16];
    int         mpc;
    logic [4:0] mfl;

    int          o_lat, o_reqc, o_illc;
    logic        o_we;
    logic [15:0] o_addr, o_wd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mr[i] = 0;
        mpc = 0;
        mfl = '0;
    endtask

    function automatic bit ovf(input int t);
        return (t > 32767) || (t < -32768);
    endfunction

    task automatic model(input logic [15:0] ins, input logic [15:0] rd,
                         output exp_t e);
        int op, d, x, s, a, b, sa, sb, i8, i4, r;
        bit wr, ill, tk;
        op = int'(ins[15:12]);
        d  = int'(ins[11:8]);
        x  = int'(ins[7:4]);
        s  = int'(ins[3:0]);
        a  = mr[d];
        b  = mr[s];
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        i8 = int'(ins[7:0]);
        if (i8 >= 128) i8 -= 256;
        i4 = (s >= 8) ? s - 16 : s;
        e = '0;
        wr = 0; ill = 0; tk = 0; r = 0;
        case (op)
            0: case (x)
                5: begin
                    r = a + b; wr = 1;
                    mfl[4] = (r > 65535);
                    mfl[2] = ovf(sa + sb);
                end
                9: begin
                    r = a - b; wr = 1;
                    mfl[4] = (a < b);
                    mfl[2] = ovf(sa - sb);
                end
                1: begin r = a & b; wr = 1; end
                2: begin r = a | b; wr = 1; end
                3: begin r = a ^ b; wr = 1; end
                11: begin
                    mfl[1] = (a == b);
                    mfl[3] = (a < b);
                    mfl[0] = (sa < sb);
                end
                13: begin r = b; wr = 1; end
                default: ill = 1;
            endcase
            5: begin
                r = a + (i8 & 'hFFFF); wr = 1;
                mfl[4] = (r > 65535);
                mfl[2] = ovf(sa + i8);
            end
            13: begin r = i8; wr = 1; end
            4: begin
                if (x == 0) begin
                    e.mem = 1; e.addr = 16'(b); r = int'(rd); wr = 1;
                end else if (x == 4) begin
                    e.mem = 1; e.st = 1;
                    e.addr = 16'(b); e.wdata = 16'(a);
                end else ill = 1;
            end
            8: begin
`ifdef DP_ARITH_SHIFT_EN
                if (x == 0 || x == 1) begin
`else
                if (x == 0) begin
`endif
                    wr = 1;
                    if (i4 >= 0) r = a << i4;
                    else if (x == 1) r = sa >>> (-i4);
                    else r = a >> (-i4);
                end else ill = 1;
            end
            12: begin
                if (d == 0) tk = mfl[1];
                else if (d == 1) tk = !mfl[1];
                else if (d == 14) tk = 1;
                else ill = 1;
            end
            default: ill = 1;
        endcase
        if (wr && !ill) mr[d] = r & 'hFFFF;
        mpc = tk ? ((mpc + i8) & 'hFFFF) : ((mpc + 1) & 'hFFFF);
        e.ill = ill;
    endtask

    task automatic exec(input logic [15:0] ins, input int waits,
                        input logic [15:0] rd);
        int cyc;
        o_lat = 0; o_reqc = 0; o_illc = 0;
        o_we = 0; o_addr = '0; o_wd = '0;
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        cyc = 1;
        while (!bus.instr_ready && cyc < 60) begin
            if (illegal) o_illc++;
            if (bus.mem_req) begin
                if (o_reqc == 0) begin
                    o_we = bus.mem_we;
                    o_addr = bus.mem_addr;
                    o_wd = bus.mem_wdata;
                end
                o_reqc++;
                if (o_reqc > waits) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = rd;
                end
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
            bus.mem_rdata = 16'($urandom);
            cyc++;
        end
        o_lat = cyc;
        chk("ready_back", 32'(bus.instr_ready), 1);
    endtask

    task automatic run(input logic [15:0] ins, input int waits,
                       input logic [15:0] rd);
        exp_t e;
        model(ins, rd, e);
        exec(ins, waits, rd);
        chk("pc", pc, mpc);
        chk("flags", 32'(flags), 32'(mfl));
        chk("illegal_cycles", o_illc, e.ill ? 1 : 0);
        chk("latency", o_lat, e.mem ? 5 + waits : 4);
        if (e.mem) begin
            chk("req_cycles", o_reqc, waits + 1);
            chk("mem_we", 32'(o_we), 32'(e.st));
            chk("mem_addr", o_addr, e.addr);
            if (e.st) chk("mem_wdata", o_wd, e.wdata);
        end else begin
            chk("no_req", o_reqc, 0);
        end
    endtask

    task automatic rand_instr(output logic [15:0] ins);
        logic [3:0] d4, s4, c4;
        logic [7:0] i8;
        d4 = 4'($urandom);
        s4 = 4'($urandom);
        i8 = 8'($urandom);
        case ($urandom_range(0, 11))
            0: ins = {4'h0, d4, 4'h5, s4};
            1: ins = {4'h0, d4, 4'h9, s4};
            2: ins = {4'h0, d4, 4'($urandom_range(1, 3)), s4};
            3: ins = {4'h0, d4, 4'hB, s4};
            4: ins = {4'h0, d4, 4'hD, s4};
            5: ins = {4'h5, d4, i8};
            6: ins = {4'hD, d4, i8};
            7: ins = {4'h4, d4, 4'h0, s4};
            8: ins = {4'h4, d4, 4'h4, s4};
            9: ins = {4'h8, d4, 4'($urandom_range(0, 1)), s4};
            10: begin
                case ($urandom_range(0, 3))
                    0: c4 = 4'h0;
                    1: c4 = 4'h1;
                    2: c4 = 4'hE;
                    default: c4 = 4'($urandom);
                endcase
                ins = {4'hC, c4, i8};
            end
            default: ins = 16'($urandom);
        endcase
    endtask

    initial begin
        logic [15:0] ins;
        bus.instr = '0;
        bus.instr_valid = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_ready", 32'(bus.instr_ready), 1);
        chk("rst_req", 32'(bus.mem_req), 0);
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_illegal", 32'(illegal), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(bus.instr_ready), 1);

        run(16'hD105, 0, 0);
        run(16'hD2FD, 0, 0);
        run(16'h0251, 0, 0);
        chk("add_flags", 32'(flags), 32'h10);
        chk("add_latency", o_lat, 4);
        run(16'hD3FF, 0, 0);
        run(16'h830F, 0, 0);
        run(16'h5301, 0, 0);
        chk("addi_flags", 32'(flags), 32'h04);
        run(16'hD420, 0, 0);
        run(16'h01B1, 0, 0);
        run(16'hD500, 0, 0);
        run(16'hD701, 0, 0);
        run(16'hC0FE, 0, 0);
        chk("beq_taken_pc", pc, 8);
        run(16'h01B2, 0, 0);
        run(16'hD800, 0, 0);
        run(16'hC0FE, 0, 0);
        chk("beq_not_taken_pc", pc, 11);
        chk("cmp_l_n", 32'({flags[3], flags[0]}), 0);
        run(16'h4144, 3, 0);
        chk("stor_req_cycles", o_reqc, 4);
        chk("stor_wdata", o_wd, 16'h0005);
        chk("stor_addr", o_addr, 16'h0020);
        run(16'h4604, 0, 16'h0005);
        run(16'h4644, 0, 0);
        chk("load_back", o_wd, 16'h0005);
        run(16'h09D3, 0, 0);
        run(16'h830F, 0, 0);
        run(16'h4344, 0, 0);
        chk("lsh_right", o_wd, 16'h4000);
        run(16'h891F, 0, 0);
        run(16'h4944, 0, 0);
`ifdef DP_ARITH_SHIFT_EN
        chk("ash_right", o_wd, 16'hC000);
`else
        chk("ash_disabled", o_wd, 16'h8000);
`endif
        run(16'hF000, 0, 0);
        chk("op_f_illegal", o_illc, 1);
        chk("op_f_pc", pc, 20);

        for (int n = 0; n < 300; n++) begin
            rand_instr(ins);
            run(ins, $urandom_range(0, 3), 16'($urandom));
        end

        bus.instr = 16'h4144;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.mem_req; i++) @(negedge clk);
        chk("mid_req_high", 32'(bus.mem_req), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_drop", 32'(bus.mem_req), 0);
        chk("async_we_drop", 32'(bus.mem_we), 0);
        chk("async_pc", pc, 0);
        chk("async_flags", 32'(flags), 0);
        chk("async_ready", 32'(bus.instr_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        run(16'h4144, 1, 0);
        chk("regs_cleared", o_wd, 0);
        run(16'h4E9C, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
